// File: rtl/clock_div_pkg.sv
`default_nettype none
// ============================================================================
// clock_div_pkg : shared state encoding and divisor helpers for clock_div_prog
// Rev 1.0 - initial release
// ============================================================================
package clock_div_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Divisors below MIN_DIV cannot form a period with both a low and high phase.
  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic int unsigned low_cycles(input int unsigned div);
    return div >> 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_div_prog_if.sv
`default_nettype none
// ============================================================================
// clock_div_prog_if : divisor configuration handshake for clock_div_prog
// Rev 1.0 - initial release
// ============================================================================
interface clock_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/clock_div_cfg_slot.sv
`default_nettype none
// ============================================================================
// clock_div_cfg_slot : single-entry divisor holding register with clamp/error
// Rev 1.0 - initial release
// ============================================================================
module clock_div_cfg_slot
  import clock_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] div,
  output logic             ready,
  output logic             err,
  input  logic             take,
  output logic [WIDTH-1:0] pend,
  output logic             pend_v
);

  logic             r_pend_v;
  logic             r_err;
  logic [WIDTH-1:0] r_pend;
  logic             w_accept;

  assign w_accept = valid & ~r_pend_v;

  // Accept and take are mutually exclusive: accept needs an empty slot, take a full one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_v <= 1'b0;
      r_pend   <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_pend   <= WIDTH'(clamp_div(32'(div)));
      r_pend_v <= 1'b1;
      r_err    <= (32'(div) < MIN_DIV);
    end else if (take) begin
      r_pend_v <= 1'b0;
    end
  end

  assign ready  = ~r_pend_v;
  assign err    = r_err;
  assign pend   = r_pend;
  assign pend_v = r_pend_v;

endmodule
`default_nettype wire

// File: rtl/clock_div_prog.sv
`default_nettype none
// ============================================================================
// clock_div_prog : runtime-programmable glitch-free integer clock divider
// Rev 1.0 - initial release
// ============================================================================
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  clock_div_prog_if.slave  cfg,
  output logic [WIDTH-1:0] cur_div,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             running
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div;
  logic             r_clk;

  logic [WIDTH-1:0] w_low;
  logic             w_last;
  logic             w_rise_pt;
  logic             w_take;
  logic             w_ready;
  logic             w_err;
  logic [WIDTH-1:0] w_pend;
  logic             w_pend_v;

  assign w_low     = WIDTH'(low_cycles(32'(r_div)));
  assign w_last    = (r_count == r_div - WIDTH'(1));
  assign w_rise_pt = (r_count == w_low - WIDTH'(1));
  // Divisor swaps only where a period is not in progress.
  assign w_take    = w_pend_v & ((r_state == STOP) | w_last);

  clock_div_cfg_slot #(
    .WIDTH (WIDTH)
  ) u_cfg_slot (
    .clock  (clock),
    .reset  (reset),
    .valid  (cfg.cfg_valid),
    .div    (cfg.cfg_div),
    .ready  (w_ready),
    .err    (w_err),
    .take   (w_take),
    .pend   (w_pend),
    .pend_v (w_pend_v)
  );

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_err   = w_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= STOP;
      r_count <= '0;
      r_clk   <= 1'b0;
      r_div   <= WIDTH'(DEFAULT_DIV);
    end else begin
      case (r_state)
        STOP: begin
          r_count <= '0;
          r_clk   <= 1'b0;
          if (w_take) r_div <= w_pend;
          if (en)     r_state <= RUN;
        end
        RUN: begin
          if (w_last) begin
            r_count <= '0;
            r_clk   <= 1'b0;
            if (w_take) r_div <= w_pend;
            if (!en)    r_state <= STOP;
          end else begin
            r_count <= r_count + WIDTH'(1);
            if (w_rise_pt) r_clk <= 1'b1;
          end
        end
        default: r_state <= STOP;
      endcase
    end
  end

  assign running  = (r_state == RUN);
  assign rise_stb = running & w_rise_pt;
  assign clk_out  = r_clk;
  assign cur_div  = r_div;

endmodule
`default_nettype wire

// File: tb/tb_clock_div_prog.sv
`default_nettype none
// ============================================================================
// tb_clock_div_prog : directed self-checking bench with a period-queue model
// Rev 1.0 - initial release
// ============================================================================
module tb_clock_div_prog;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             en    = 1'b0;
  logic [WIDTH-1:0] cur_div;
  logic             clk_out;
  logic             rise_stb;
  logic             running;

  clock_div_prog_if #(.WIDTH(WIDTH)) cfg ();

  clock_div_prog #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .cfg      (cfg.slave),
    .cur_div  (cur_div),
    .clk_out  (clk_out),
    .rise_stb (rise_stb),
    .running  (running)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each period is a queue of output levels, floor(N/2) lows then ceil(N/2) highs.
  bit m_valid = 1'b0;
  bit m_run, m_pend_v, m_err;
  int m_div, m_pend;
  bit m_wave[$];

  function automatic void start_period();
    m_wave.delete();
    for (int i = 0; i < m_div / 2; i++)       m_wave.push_back(1'b0);
    for (int i = 0; i < (m_div + 1) / 2; i++) m_wave.push_back(1'b1);
  endfunction

  always @(posedge clock) begin : model
    bit acc;
    bit at_edge;
    if (reset) begin
      m_run    = 1'b0;
      m_wave.delete();
      m_div    = DEFAULT_DIV;
      m_pend_v = 1'b0;
      m_pend   = 0;
      m_err    = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      acc     = cfg.cfg_valid && !m_pend_v;
      at_edge = !m_run || (m_wave.size() == 1);
      if (m_run) void'(m_wave.pop_front());
      if (at_edge) begin
        if (m_pend_v) begin
          m_div    = m_pend;
          m_pend_v = 1'b0;
        end
        m_run = en;
        if (en) start_period();
      end
      if (acc) begin
        m_pend   = (cfg.cfg_div < 2) ? 2 : int'(cfg.cfg_div);
        m_pend_v = 1'b1;
        m_err    = (cfg.cfg_div < 2);
      end
    end
  end

  always @(negedge clock) begin : compare
    bit exp_clk, exp_rise;
    if (m_valid) begin
      exp_clk  = m_run && (m_wave.size() > 0) && m_wave[0];
      exp_rise = m_run && (m_wave.size() >= 2) && !m_wave[0] && m_wave[1];
      check("model_clk_out",   32'(clk_out),       32'(exp_clk));
      check("model_rise_stb",  32'(rise_stb),      32'(exp_rise));
      check("model_running",   32'(running),       32'(m_run));
      check("model_cur_div",   32'(cur_div),       32'(m_div));
      check("model_cfg_ready", 32'(cfg.cfg_ready), 32'(!m_pend_v));
      check("model_cfg_err",   32'(cfg.cfg_err),   32'(m_err));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_cfg(input int d);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = WIDTH'(d);
    @(negedge clock);
    cfg.cfg_valid = 1'b0;
  endtask

  // Literal waveform; leftmost bit of exp is the first sampled cycle.
  task automatic expect_wave(input string name, input int n, input logic [31:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check(name, 32'(clk_out), 32'(exp[n-1-i]));
    end
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    wait_neg(3);
    check("reset_cur_div",   32'(cur_div),       32'd4);
    check("reset_clk_out",   32'(clk_out),       32'd0);
    check("reset_running",   32'(running),       32'd0);
    check("reset_cfg_ready", 32'(cfg.cfg_ready), 32'd1);
    check("reset_cfg_err",   32'(cfg.cfg_err),   32'd0);

    reset = 1'b0;
    en    = 1'b1;
    expect_wave("div4_start", 8, 32'b00110011);

    wait_neg(2);
    pulse_cfg(3);
    check("div3_pending_ready", 32'(cfg.cfg_ready), 32'd0);
    expect_wave("div4_to_div3", 7, 32'b1011011);
    check("div3_cur_div", 32'(cur_div),       32'd3);
    check("div3_ready",   32'(cfg.cfg_ready), 32'd1);

    pulse_cfg(2);
    wait_neg(4);
    pulse_cfg(6);
    expect_wave("div2_then_div6", 7, 32'b1000111);
    check("div6_cur_div", 32'(cur_div), 32'd6);

    pulse_cfg(0);
    check("div0_err_set",   32'(cfg.cfg_err),   32'd1);
    check("div0_not_ready", 32'(cfg.cfg_ready), 32'd0);
    check("div0_not_yet",   32'(cur_div),       32'd6);
    wait_neg(6);
    check("div0_clamped", 32'(cur_div), 32'd2);

    pulse_cfg(1);
    wait_neg(1);
    check("div1_err_set", 32'(cfg.cfg_err), 32'd1);
    check("div1_clamped", 32'(cur_div),     32'd2);

    pulse_cfg(5);
    check("div5_err_clear", 32'(cfg.cfg_err), 32'd0);
    expect_wave("div5_wave", 5, 32'b00111);
    check("div5_cur_div", 32'(cur_div), 32'd5);

    pulse_cfg(4);
    check("boundary_accept_not_applied", 32'(cur_div), 32'd5);
    wait_neg(7);
    check("stop_point_high", 32'(clk_out), 32'd1);
    en = 1'b0;
    expect_wave("stop_completes_period", 6, 32'b100000);
    check("stopped", 32'(running), 32'd0);

    en = 1'b1;
    expect_wave("restart_period", 4, 32'b0011);

    pulse_cfg(7);
    wait_neg(2);
    check("pre_reset_high",  32'(clk_out),       32'd1);
    check("pre_reset_pend",  32'(cfg.cfg_ready), 32'd0);
    reset = 1'b1;
    wait_neg(1);
    check("mid_reset_clk_out",   32'(clk_out),       32'd0);
    check("mid_reset_cur_div",   32'(cur_div),       32'd4);
    check("mid_reset_cfg_ready", 32'(cfg.cfg_ready), 32'd1);
    check("mid_reset_running",   32'(running),       32'd0);

    reset = 1'b0;
    wait_neg(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_div_prog.md
Name: clock_div_prog

Overview:
Synthesizable, runtime-programmable integer clock divider. It is the neighbouring stage to the unsynthesizable fixed-ratio simulation divider.
- Consumes the fast clock.
- Produces a registered divided clock with the same duty-cycle rule: high for ceil(N/2) of every N input cycles.
- Divisor is reprogrammed over a valid/ready handshake and applied only at period boundaries, so the output is glitch-free.
- A cycle-early rise strobe lets fast-domain logic align with divided-clock edges.

Parameters:
WIDTH, 8, width of divisor and counter.
DEFAULT_DIV, 4, divisor loaded at reset; must be >= 2 and < 2^WIDTH.

Ports:
clock  in  1  fast input clock; all state on posedge.
reset  in  1  synchronous, active-high reset.
en  in  1  run request; sampled every cycle.
cfg_valid  in  1  new divisor offered.
cfg_div  in  WIDTH  offered divisor.
cfg_ready  out  1  config slot empty; transfer when cfg_valid & cfg_ready.
cfg_err  out  1  sticky: last accepted divisor was < 2 and was clamped.
cur_div  out  WIDTH  divisor currently in effect (div_q).
clk_out  out  1  divided clock, driven directly from a flop.
rise_stb  out  1  high in the cycle before clk_out rises.
running  out  1  state == RUN.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=STOP, count=0, clk_out=0, div_q=DEFAULT_DIV, pend_v=0, cfg_ready=1, cfg_err=0, rise_stb=0.
  - Reset mid-period truncates the output to low with no extra edge.
- Derived value: LOW = div_q >> 1.
- Invariant in RUN: clk_out==1 iff LOW <= count <= div_q-1.
  - Example div=4 gives 0,0,1,1.
  - Example div=3 gives 0,1,1.
- STOP state:
  - count=0, clk_out=0.
  - If pend_v: div_q<=pend, pend_v<=0 next cycle.
  - If en=1: go to RUN next cycle with count=0. A pending apply and RUN entry may coincide; the new div_q governs the first period.
- RUN state, each cycle:
  - If count==div_q-1 (boundary):
    - count<=0, clk_out<=0.
    - If pend_v: div_q<=pend, pend_v<=0.
    - If en==0: state<=STOP.
  - Else:
    - count<=count+1.
    - If count==LOW-1: clk_out<=1.
- rise_stb = running & count==LOW-1, combinational from registers.
- Stopping: en deassertion mid-period completes the current period. The block never produces a runt pulse.
- Config handshake:
  - cfg_ready = !pend_v.
  - On accept: pend <= (cfg_div<2 ? 2 : cfg_div), pend_v<=1, cfg_err <= (cfg_div<2).
  - A value accepted in the same cycle as a boundary is NOT applied at that boundary; it waits for the next boundary.
  - While pend_v=1, cfg_ready=0 and cfg_valid is ignored.
- Arithmetic:
  - count and div_q are WIDTH bits unsigned.
  - div_q-1 cannot underflow because div_q>=2 always.
  - Maximum divisor is 2^WIDTH-1.
- cur_div changes only at a boundary or in STOP, never mid-period.

Decomposition:
- Package clock_div_pkg:
  - state enum {STOP, RUN}.
  - localparam MIN_DIV=2.
  - function clamp_div().
  - function low_cycles(div) = div>>1.
- One natural sub-module: clock_div_cfg_slot, a single-entry holding register with the valid/ready handshake and clamp/err logic.
- Counter and FSM stay in the top module.

Test Plan:
- Reset, en=1, DEFAULT_DIV=4: first clk_out rise 3 cycles after RUN entry; pattern 0,0,1,1 repeats; rise_stb high when count==1; cur_div=4.
- Program cfg_div=3 at count==1 of a div-4 period: that period finishes as 4 cycles; cfg_ready low until the boundary, then high; the following periods read 0,1,1.
- Offer cfg_div=6 in the exact boundary cycle of a div-2 stream: one further 2-cycle period runs, then 0,0,0,1,1,1.
- cfg_div=0, then cfg_div=1: cur_div becomes 2 and cfg_err=1 after each. A later cfg_div=5 clears cfg_err, and clk_out reads 0,0,1,1,1.
- Drop en at count==2 of a div-4 period: clk_out stays high through count 3, falls at the boundary, running=0, no further edges. Reassert en: a new period starts at count 0.
- Assert reset while clk_out=1 mid-period with pend_v=1: next cycle clk_out=0, pend discarded, cur_div=DEFAULT_DIV, cfg_ready=1, state STOP.
